time_date_editor: RTL and testbench

Button-driven set controller for the decade clock/calendar. It debounces the three raw push-buttons and walks a field-select state machine through hour, minute, second, day, month and year. Edits are held in BCD shadow registers and written back to the time/date counter through one-cycle load strobes. This is the write side into the counter; the display path is the read side. It also drives a blink mask and a display-mode hint so the field being edited flashes on the 7-segment digits.

---
 rtl/time_date_editor.sv | 235 +++++++++++++++++++++++
 tb/tb_time_date_editor.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/time_date_editor.sv
// Button-driven set controller for the BCD clock/calendar: debounced buttons
// walk hour..year, edits live in shadow registers and are committed by load strobes.
module tde_debounce #(
  parameter int            DBW = 20,
  parameter logic [DBW-1:0] DEBOUNCE_CYCLES = 20'd999_999
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n_i,
  output logic press_o
);
  logic [1:0]     sync_q;
  logic           stable_q;
  logic [DBW-1:0] cnt_q;
  logic           press_q;

  // cnt_q counts consecutive cycles the synced level differs from the accepted one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= 2'b11;
      stable_q <= 1'b1;
      cnt_q    <= '0;
      press_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], btn_n_i};
      press_q <= 1'b0;
      if (sync_q[1] == stable_q) begin
        cnt_q <= '0;
      end else if (cnt_q == DEBOUNCE_CYCLES) begin
        stable_q <= sync_q[1];
        cnt_q    <= '0;
        press_q  <= ~sync_q[1];
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign press_o = press_q;
endmodule

module time_date_editor #(
  parameter int             DBW = 20,
  parameter logic [DBW-1:0] DEBOUNCE_CYCLES = 20'd999_999,
  parameter int             BLW = 24,
  parameter logic [BLW-1:0] BLINK_COUNT = 24'd12_499_999
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        butt_increase,
  input  logic        butt_decrease,
  input  logic        butt_change,
  input  logic [23:0] cur_time,
  input  logic [31:0] cur_date,
  output logic [23:0] set_time,
  output logic [31:0] set_date,
  output logic        load_time,
  output logic        load_date,
  output logic        edit_active,
  output logic [2:0]  field_sel,
  output logic        show_date,
  output logic [7:0]  blink_mask
);
  typedef enum logic [2:0] {IDLE, HOUR, MIN, SEC, DAY, MONTH, YEAR, COMMIT} state_e;

  state_e         state_q, state_d;
  logic [23:0]    time_q, time_d;
  logic [31:0]    date_q, date_d;
  logic [BLW-1:0] bcnt_q, bcnt_d;
  logic           phase_q, phase_d;
  logic [2:0]     btn_n, press;
  logic           chg_p, inc_p, dec_p, step;

  assign btn_n = {butt_change, butt_increase, butt_decrease};
  for (genvar g = 0; g < 3; g++) begin : g_db
    tde_debounce #(.DBW(DBW), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk(clk), .rst_n(rst_n), .btn_n_i(btn_n[g]), .press_o(press[g]));
  end

  assign chg_p = press[2];
  assign inc_p = press[1] & ~press[0] & ~chg_p;
  assign dec_p = press[0] & ~press[1] & ~chg_p;
  assign step  = inc_p | dec_p;

  function automatic logic [6:0] bcd2bin(input logic [7:0] b);
    return 7'({3'b0, b[7:4]} * 7'd10 + {3'b0, b[3:0]});
  endfunction

  function automatic logic [7:0] bin2bcd(input logic [6:0] v);
    logic [6:0] t, o;
    t = v / 7'd10;
    o = v % 7'd10;
    return {t[3:0], o[3:0]};
  endfunction

  // Out-of-range inputs (odd snapshots) wrap like the top of the range
  function automatic logic [7:0] step2(input logic [7:0] b, input logic up,
                                       input logic [6:0] lo, input logic [6:0] hi);
    logic [6:0] v;
    v = bcd2bin(b);
    if (up) v = (v >= hi) ? lo : v + 7'd1;
    else    v = (v <= lo || v > hi) ? hi : v - 7'd1;
    return bin2bcd(v);
  endfunction

  function automatic logic [15:0] step_year(input logic [15:0] y, input logic up);
    logic [15:0] r;
    logic [3:0]  d;
    logic        c;
    r = y;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      d = r[4*i +: 4];
      if (c) begin
        if (up) begin
          c = (d >= 4'd9);
          d = c ? 4'd0 : d + 4'd1;
        end else begin
          c = (d == 4'd0);
          d = c ? 4'd9 : d - 4'd1;
        end
      end
      r[4*i +: 4] = d;
    end
    return r;
  endfunction

  function automatic logic div4(input logic [3:0] t, input logic [3:0] o);
    return t[0] ? (o == 4'd2 || o == 4'd6) : (o == 4'd0 || o == 4'd4 || o == 4'd8);
  endfunction

  function automatic logic leap(input logic [15:0] y);
    return (y[7:0] == 8'h00) ? div4(y[15:12], y[11:8]) : div4(y[7:4], y[3:0]);
  endfunction

  function automatic logic [6:0] maxday(input logic [7:0] mon, input logic lp);
    case (bcd2bin(mon))
      7'd2:                      return lp ? 7'd29 : 7'd28;
      7'd4, 7'd6, 7'd9, 7'd11:  return 7'd30;
      default:                   return 7'd31;
    endcase
  endfunction

  always_comb begin
    logic [7:0]  new_mon;
    logic [15:0] new_yr;
    logic [6:0]  md;
    state_d = state_q;
    time_d  = time_q;
    date_d  = date_q;
    new_mon = date_q[23:16];
    new_yr  = date_q[15:0];
    md      = 7'd31;
    case (state_q)
      IDLE: if (chg_p) begin
        time_d  = cur_time;
        date_d  = cur_date;
        state_d = HOUR;
      end
      HOUR: if (chg_p) state_d = MIN;
            else if (step) time_d[23:16] = step2(time_q[23:16], inc_p, 7'd0, 7'd23);
      MIN:  if (chg_p) state_d = SEC;
            else if (step) time_d[15:8] = step2(time_q[15:8], inc_p, 7'd0, 7'd59);
      SEC:  if (chg_p) state_d = DAY;
            else if (step) time_d[7:0] = step2(time_q[7:0], inc_p, 7'd0, 7'd59);
      DAY:  if (chg_p) state_d = MONTH;
            else if (step) date_d[31:24] = step2(date_q[31:24], inc_p, 7'd1,
                                               maxday(date_q[23:16], leap(date_q[15:0])));
      MONTH, YEAR: begin
        if (chg_p) begin
          state_d = (state_q == MONTH) ? YEAR : COMMIT;
        end else if (step) begin
          if (state_q == MONTH) new_mon = step2(date_q[23:16], inc_p, 7'd1, 7'd12);
          else                  new_yr  = step_year(date_q[15:0], inc_p);
          md = maxday(new_mon, leap(new_yr));
          date_d[23:0] = {new_mon, new_yr};
          if (bcd2bin(date_q[31:24]) > md) date_d[31:24] = bin2bcd(md);
        end
      end
      COMMIT: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Blink counter idles at zero, so entering HOUR always starts a fresh phase
  always_comb begin
    bcnt_d  = '0;
    phase_d = 1'b0;
    if (state_q != IDLE) begin
      if (bcnt_q == BLINK_COUNT) begin
        phase_d = ~phase_q;
      end else begin
        bcnt_d  = bcnt_q + 1'b1;
        phase_d = phase_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      time_q  <= '0;
      date_q  <= '0;
      bcnt_q  <= '0;
      phase_q <= 1'b0;
    end else begin
      state_q <= state_d;
      time_q  <= time_d;
      date_q  <= date_d;
      bcnt_q  <= bcnt_d;
      phase_q <= phase_d;
    end
  end

  always_comb begin
    blink_mask = 8'h00;
    if (phase_q) begin
      case (state_q)
        HOUR, DAY:  blink_mask = 8'hC0;
        MIN, MONTH: blink_mask = 8'h30;
        SEC:        blink_mask = 8'h0C;
        YEAR:       blink_mask = 8'h0F;
        default:    blink_mask = 8'h00;
      endcase
    end
  end

  assign set_time    = time_q;
  assign set_date    = date_q;
  assign load_time   = (state_q == COMMIT);
  assign load_date   = (state_q == COMMIT);
  assign edit_active = (state_q != IDLE);
  assign field_sel   = (state_q == COMMIT) ? 3'd0 : state_q;
  assign show_date   = (state_q == DAY) || (state_q == MONTH) || (state_q == YEAR);
endmodule

// File: tb/tb_time_date_editor.sv
// Directed bench for time_date_editor: table of button presses with expected
// shadow values, plus hand sequences for glitch, blink, commit and reset.
module tb_time_date_editor;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        butt_increase = 1'b1, butt_decrease = 1'b1, butt_change = 1'b1;
  logic [23:0] cur_time = 24'h123456;
  logic [31:0] cur_date = 32'h31012023;
  logic [23:0] set_time;
  logic [31:0] set_date;
  logic        load_time, load_date, edit_active, show_date;
  logic [2:0]  field_sel;
  logic [7:0]  blink_mask;

  int n_chk = 0, n_fail = 0, load_cnt = 0;

  time_date_editor #(.DEBOUNCE_CYCLES(20'd3), .BLINK_COUNT(24'd7)) dut (
    .clk(clk), .rst_n(rst_n), .butt_increase(butt_increase), .butt_decrease(butt_decrease),
    .butt_change(butt_change), .cur_time(cur_time), .cur_date(cur_date),
    .set_time(set_time), .set_date(set_date), .load_time(load_time), .load_date(load_date),
    .edit_active(edit_active), .field_sel(field_sel), .show_date(show_date),
    .blink_mask(blink_mask));

  always #5 clk = ~clk;
  always @(posedge clk) if (load_time) load_cnt++;

  typedef struct {
    logic [2:0]  btn;   // {change, increase, decrease}
    int          reps;
    logic [31:0] cd;
    logic [2:0]  sel;
    logic [23:0] t;
    logic [31:0] d;
  } vec_t;
  vec_t vq[$];

  task automatic add(input logic [2:0] b, input int n, input logic [31:0] cd,
                     input logic [2:0] s, input logic [23:0] t, input logic [31:0] d);
    vec_t v;
    v.btn = b; v.reps = n; v.cd = cd; v.sel = s; v.t = t; v.d = d;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic press(input logic [2:0] b);
    @(negedge clk);
    butt_change = ~b[2]; butt_increase = ~b[1]; butt_decrease = ~b[0];
    repeat (10) @(negedge clk);
    butt_change = 1'b1; butt_increase = 1'b1; butt_decrease = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic pressn(input logic [2:0] b, input int n);
    for (int i = 0; i < n; i++) press(b);
  endtask

  initial begin
    int t, lc, loads, after;
    logic [7:0]  v;
    logic [23:0] gt;
    logic [31:0] gd;

    // Table: HOUR/MIN/SEC/DAY/MONTH/YEAR edits, wraps, clamps, priority
    add(3'b100,  1, 32'h31012023, 3'd1, 24'h123456, 32'h31012023);
    add(3'b010, 11, 32'h31012023, 3'd1, 24'h233456, 32'h31012023);
    add(3'b010,  1, 32'h31012023, 3'd1, 24'h003456, 32'h31012023);
    add(3'b001,  1, 32'h31012023, 3'd1, 24'h233456, 32'h31012023);
    add(3'b011,  1, 32'h31012023, 3'd1, 24'h233456, 32'h31012023);
    add(3'b110,  1, 32'h31012023, 3'd2, 24'h233456, 32'h31012023);
    add(3'b010, 25, 32'h31012023, 3'd2, 24'h235956, 32'h31012023);
    add(3'b010,  1, 32'h31012023, 3'd2, 24'h230056, 32'h31012023);
    add(3'b001,  1, 32'h31012023, 3'd2, 24'h235956, 32'h31012023);
    add(3'b100,  1, 32'h31012023, 3'd3, 24'h235956, 32'h31012023);
    add(3'b001,  1, 32'h31012023, 3'd3, 24'h235955, 32'h31012023);
    add(3'b100,  1, 32'h31012023, 3'd4, 24'h235955, 32'h31012023);
    add(3'b010,  1, 32'h31012023, 3'd4, 24'h235955, 32'h01012023);
    add(3'b001,  1, 32'h31012023, 3'd4, 24'h235955, 32'h31012023);
    add(3'b100,  1, 32'h31012023, 3'd5, 24'h235955, 32'h31012023);
    add(3'b010,  1, 32'h31012023, 3'd5, 24'h235955, 32'h28022023);
    add(3'b001,  2, 32'h31012023, 3'd5, 24'h235955, 32'h28122023);
    add(3'b010,  2, 32'h31012023, 3'd5, 24'h235955, 32'h28022023);
    add(3'b100,  1, 32'h31012023, 3'd6, 24'h235955, 32'h28022023);
    add(3'b010,  1, 32'h31012023, 3'd6, 24'h235955, 32'h28022024);
    add(3'b100,  1, 32'h31012023, 3'd0, 24'h235955, 32'h28022024);
    add(3'b100,  1, 32'h29022023, 3'd1, 24'h123456, 32'h29022023);
    add(3'b100,  5, 32'h29022023, 3'd6, 24'h123456, 32'h29022023);
    add(3'b010,  1, 32'h29022023, 3'd6, 24'h123456, 32'h29022024);
    add(3'b010,  1, 32'h29022023, 3'd6, 24'h123456, 32'h28022025);
    add(3'b100,  1, 32'h29022023, 3'd0, 24'h123456, 32'h28022025);
    add(3'b100,  6, 32'h29022099, 3'd6, 24'h123456, 32'h29022099);
    add(3'b010,  1, 32'h29022099, 3'd6, 24'h123456, 32'h28022100);
    add(3'b100,  1, 32'h29022099, 3'd0, 24'h123456, 32'h28022100);
    add(3'b100,  6, 32'h15070000, 3'd6, 24'h123456, 32'h15070000);
    add(3'b001,  1, 32'h15070000, 3'd6, 24'h123456, 32'h15079999);
    add(3'b010,  1, 32'h15070000, 3'd6, 24'h123456, 32'h15070000);
    add(3'b100,  1, 32'h15070000, 3'd0, 24'h123456, 32'h15070000);
    add(3'b100,  5, 32'h31031900, 3'd5, 24'h123456, 32'h31031900);
    add(3'b010,  1, 32'h31031900, 3'd5, 24'h123456, 32'h30041900);
    add(3'b100,  2, 32'h31031900, 3'd0, 24'h123456, 32'h30041900);

    repeat (3) @(negedge clk);
    chk("rst_set_time", set_time, 0);
    chk("rst_set_date", set_date, 0);
    chk("rst_loads", {load_time, load_date}, 0);
    chk("rst_edit", edit_active, 0);
    chk("rst_sel", field_sel, 0);
    chk("rst_show", show_date, 0);
    chk("rst_mask", blink_mask, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    foreach (vq[i]) begin
      cur_date = vq[i].cd;
      pressn(vq[i].btn, vq[i].reps);
      chk($sformatf("v%0d_sel", i), field_sel, vq[i].sel);
      chk($sformatf("v%0d_time", i), set_time, vq[i].t);
      chk($sformatf("v%0d_date", i), set_date, vq[i].d);
      chk($sformatf("v%0d_edit", i), edit_active, vq[i].sel != 0);
      chk($sformatf("v%0d_show", i), show_date, vq[i].sel >= 4 && vq[i].sel <= 6);
    end

    // Full walk to 23:59:58 29/02/2000 with glitch and blink checks on the way
    cur_time = 24'h235957;
    cur_date = 32'h29021999;
    press(3'b100);
    chk("b_snap_time", set_time, 24'h235957);
    @(negedge clk) butt_increase = 1'b0;
    repeat (2) @(negedge clk);
    butt_increase = 1'b1;
    repeat (12) @(negedge clk);
    chk("glitch_hour", set_time, 24'h235957);
    pressn(3'b100, 2);
    chk("b_sel_sec", field_sel, 3'd3);

    t = 0;
    v = blink_mask;
    do begin @(negedge clk); t++; end while (blink_mask == v && t < 40);
    chk("blink_edge_seen", t < 40, 1);
    v = blink_mask;
    chk("blink_val", (v == 8'h0C) || (v == 8'h00), 1);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k < 8) chk($sformatf("blink_hold%0d", k), blink_mask, v);
      else       chk("blink_flip", blink_mask, v ^ 8'h0C);
    end

    press(3'b010);
    chk("b_sec58", set_time, 24'h235958);
    pressn(3'b100, 3);
    chk("b_sel_year", field_sel, 3'd6);
    press(3'b010);
    chk("b_y2000_keep29", set_date, 32'h29022000);

    lc = load_cnt;
    loads = 0; after = 0; gt = '0; gd = '0;
    @(negedge clk) butt_change = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (after == 1) begin
        chk("post_commit_edit", edit_active, 0);
        chk("post_commit_mask", blink_mask, 0);
        after = 2;
      end
      if (load_time || load_date) begin
        loads++;
        chk("commit_pair", {load_time, load_date}, 2'b11);
        gt = set_time; gd = set_date;
        after = 1;
      end
    end
    butt_change = 1'b1;
    repeat (10) @(negedge clk);
    chk("commit_pulses", loads, 1);
    chk("commit_edge_count", load_cnt - lc, 1);
    chk("commit_time", gt, 24'h235958);
    chk("commit_date", gd, 32'h29022000);

    // Reset in MONTH: no strobe, shadows cleared at once
    lc = load_cnt;
    pressn(3'b100, 5);
    chk("r_sel_month", field_sel, 3'd5);
    @(negedge clk) rst_n = 1'b0;
    #1;
    chk("r_sel", field_sel, 0);
    chk("r_edit", edit_active, 0);
    chk("r_time", set_time, 0);
    chk("r_date", set_date, 0);
    chk("r_load", {load_time, load_date}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("r_still_idle", field_sel, 0);
    chk("r_no_load", load_cnt - lc, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, limit 2000000 reached");
    $fatal(1);
  end
endmodule
